// File: rtl/divisor_segmentado_cfg_if.sv
// Operand/result handshake bundle for the pipelined divider.
// The slave side is the divider; the master side is the arbiter/FIFO pair feeding and draining it.
interface divisor_segmentado_cfg_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic             in_signed;
    logic [WIDTH-1:0] in_num;
    logic [WIDTH-1:0] in_den;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_coc;
    logic [WIDTH-1:0] out_res;
    logic [TAG_W-1:0] out_tag;
    logic             out_div0;
    logic             out_ovf;

    modport slave (
        input  in_valid, in_signed, in_num, in_den, in_tag, out_ready,
        output in_ready, out_valid, out_coc, out_res, out_tag, out_div0, out_ovf
    );

    modport master (
        output in_valid, in_signed, in_num, in_den, in_tag, out_ready,
        input  in_ready, out_valid, out_coc, out_res, out_tag, out_div0, out_ovf
    );
endinterface

// File: rtl/divisor_segmentado_cfg.sv
// Fully pipelined restoring divider: input stage (magnitudes, signs), WIDTH/BITS_PER_STAGE
// compute stages, output stage (sign fix, flags). One operation per cycle, global stall.
module divisor_segmentado_cfg #(
    parameter int unsigned WIDTH          = 32,
    parameter int unsigned BITS_PER_STAGE = 1,
    parameter int unsigned TAG_W          = 4
) (
    input  logic                      CLK,
    input  logic                      RSTa,
    divisor_segmentado_cfg_if.slave   bus
);
    localparam int unsigned S = WIDTH / BITS_PER_STAGE;
    localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

    typedef struct packed {
        logic             v;
        logic             neg_q;
        logic             neg_r;
        logic             div0;
        logic             ovf;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] den;
        logic [WIDTH-1:0] rem;
        logic [WIDTH-1:0] q;
    } stage_t;

    stage_t pipe [0:S];
    stage_t in_stage;

    logic             adv;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_coc_q;
    logic [WIDTH-1:0] out_res_q;
    logic [TAG_W-1:0] out_tag_q;
    logic             out_div0_q;
    logic             out_ovf_q;
    logic             num_neg;
    logic             den_neg;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // q holds the not-yet-consumed dividend bits at its top and the grown quotient at its bottom.
    function automatic stage_t step(input stage_t s);
        stage_t         t;
        logic [WIDTH:0] trial;
        t = s;
        for (int unsigned b = 0; b < BITS_PER_STAGE; b++) begin
            trial = {t.rem, t.q[WIDTH-1]};
            t.q   = {t.q[WIDTH-2:0], 1'b0};
            if (trial >= {1'b0, t.den}) begin
                trial  = trial - {1'b0, t.den};
                t.q[0] = 1'b1;
            end
            t.rem = trial[WIDTH-1:0];
        end
        return t;
    endfunction

    assign adv          = !out_valid_q || bus.out_ready;
    assign bus.in_ready = adv && !RSTa;

    always_comb begin
        num_neg        = bus.in_signed && bus.in_num[WIDTH-1];
        den_neg        = bus.in_signed && bus.in_den[WIDTH-1];
        in_stage       = '0;
        in_stage.v     = bus.in_valid;
        in_stage.neg_q = num_neg ^ den_neg;
        in_stage.neg_r = num_neg;
        in_stage.div0  = (bus.in_den == '0);
        in_stage.ovf   = bus.in_signed && (bus.in_num == MIN_V) && (bus.in_den == '1);
        in_stage.tag   = bus.in_tag;
        in_stage.den   = den_neg ? -bus.in_den : bus.in_den;
        in_stage.rem   = '0;
        in_stage.q     = num_neg ? -bus.in_num : bus.in_num;
    end

    // A zero divisor leaves rem = |num|, so the remainder sign fix restores num without an override;
    // MIN / -1 likewise falls out of the magnitude path, only the flag is needed.
    always_comb begin
        q_fix = pipe[S].neg_q ? -pipe[S].q : pipe[S].q;
        r_fix = pipe[S].neg_r ? -pipe[S].rem : pipe[S].rem;
    end

    always_ff @(posedge CLK) begin
        if (RSTa) begin
            for (int unsigned k = 0; k <= S; k++) begin
                pipe[k].v <= 1'b0;
            end
            out_valid_q <= 1'b0;
            out_coc_q   <= '0;
            out_res_q   <= '0;
            out_tag_q   <= '0;
            out_div0_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
        end else if (adv) begin
            pipe[0] <= in_stage;
            for (int unsigned k = 1; k <= S; k++) begin
                pipe[k] <= step(pipe[k-1]);
            end
            out_valid_q <= pipe[S].v;
            if (pipe[S].v) begin
                out_coc_q  <= pipe[S].div0 ? '1 : q_fix;
                out_res_q  <= r_fix;
                out_tag_q  <= pipe[S].tag;
                out_div0_q <= pipe[S].div0;
                out_ovf_q  <= pipe[S].ovf;
            end else begin
                out_coc_q  <= '0;
                out_res_q  <= '0;
                out_tag_q  <= '0;
                out_div0_q <= 1'b0;
                out_ovf_q  <= 1'b0;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_coc   = out_coc_q;
    assign bus.out_res   = out_res_q;
    assign bus.out_tag   = out_tag_q;
    assign bus.out_div0  = out_div0_q;
    assign bus.out_ovf   = out_ovf_q;
endmodule

// File: tb/tb_divisor_segmentado_cfg.sv
// Bench for divisor_segmentado_cfg: directed vector table on the 32-bit/1-bit-per-stage build,
// streaming and stall sequences on 32/1, 8/2 and 16/4 builds against a longint reference.
module tb_divisor_segmentado_cfg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    divisor_segmentado_cfg_if #(.WIDTH(32), .TAG_W(4)) if0 ();
    divisor_segmentado_cfg_if #(.WIDTH(8),  .TAG_W(4)) if1 ();
    divisor_segmentado_cfg_if #(.WIDTH(16), .TAG_W(4)) if2 ();

    divisor_segmentado_cfg #(.WIDTH(32), .BITS_PER_STAGE(1), .TAG_W(4)) u0 (.CLK(clk), .RSTa(rst), .bus(if0));
    divisor_segmentado_cfg #(.WIDTH(8),  .BITS_PER_STAGE(2), .TAG_W(4)) u1 (.CLK(clk), .RSTa(rst), .bus(if1));
    divisor_segmentado_cfg #(.WIDTH(16), .BITS_PER_STAGE(4), .TAG_W(4)) u2 (.CLK(clk), .RSTa(rst), .bus(if2));

    int unsigned cfg_w [3] = '{32, 8, 16};
    int          cfg_l [3] = '{34, 6, 6};

    logic        d_valid [3];
    logic        d_signed[3];
    logic        d_ready [3];
    logic [31:0] d_num   [3];
    logic [31:0] d_den   [3];
    logic [3:0]  d_tag   [3];

    logic        o_valid [3];
    logic        o_rdy   [3];
    logic [31:0] o_coc   [3];
    logic [31:0] o_res   [3];
    logic [3:0]  o_tag   [3];
    logic        o_div0  [3];
    logic        o_ovf   [3];

    assign if0.in_valid  = d_valid[0];
    assign if0.in_signed = d_signed[0];
    assign if0.in_num    = d_num[0];
    assign if0.in_den    = d_den[0];
    assign if0.in_tag    = d_tag[0];
    assign if0.out_ready = d_ready[0];
    assign if1.in_valid  = d_valid[1];
    assign if1.in_signed = d_signed[1];
    assign if1.in_num    = d_num[1][7:0];
    assign if1.in_den    = d_den[1][7:0];
    assign if1.in_tag    = d_tag[1];
    assign if1.out_ready = d_ready[1];
    assign if2.in_valid  = d_valid[2];
    assign if2.in_signed = d_signed[2];
    assign if2.in_num    = d_num[2][15:0];
    assign if2.in_den    = d_den[2][15:0];
    assign if2.in_tag    = d_tag[2];
    assign if2.out_ready = d_ready[2];

    always_comb begin
        o_valid[0] = if0.out_valid;  o_rdy[0] = if0.in_ready;
        o_coc[0]   = if0.out_coc;    o_res[0] = if0.out_res;
        o_tag[0]   = if0.out_tag;    o_div0[0] = if0.out_div0;  o_ovf[0] = if0.out_ovf;
        o_valid[1] = if1.out_valid;  o_rdy[1] = if1.in_ready;
        o_coc[1]   = {24'h0, if1.out_coc};  o_res[1] = {24'h0, if1.out_res};
        o_tag[1]   = if1.out_tag;    o_div0[1] = if1.out_div0;  o_ovf[1] = if1.out_ovf;
        o_valid[2] = if2.out_valid;  o_rdy[2] = if2.in_ready;
        o_coc[2]   = {16'h0, if2.out_coc};  o_res[2] = {16'h0, if2.out_res};
        o_tag[2]   = if2.out_tag;    o_div0[2] = if2.out_div0;  o_ovf[2] = if2.out_ovf;
    end

    typedef struct {
        logic        sgn;
        logic [31:0] num;
        logic [31:0] den;
        logic [3:0]  tag;
        logic [31:0] coc;
        logic [31:0] res;
        logic        dz;
        logic        ov;
    } vec_t;

    vec_t vecs [13];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Independent reference: sign-extend to 64 bits and use the language's truncating / and %.
    function automatic void ref_div(input int unsigned w, input logic sgn, input logic [31:0] n_in,
                                    input logic [31:0] d_in, output logic [31:0] q, output logic [31:0] r,
                                    output logic dz, output logic ov);
        longint      sn, sd;
        logic [31:0] mask, minv, n, d;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        minv = 32'd1 << (w - 1);
        n = n_in & mask;
        d = d_in & mask;
        dz = (d == 0);
        ov = sgn && (n == minv) && (d == mask);
        if (dz) begin
            q = mask; r = n;
        end else if (ov) begin
            q = minv; r = 0;
        end else if (sgn) begin
            sn = ((n & minv) != 0) ? longint'(n) - (longint'(1) << w) : longint'(n);
            sd = ((d & minv) != 0) ? longint'(d) - (longint'(1) << w) : longint'(d);
            q = 32'(sn / sd) & mask;
            r = 32'(sn % sd) & mask;
        end else begin
            q = n / d; r = n % d;
        end
    endfunction

    task automatic run_vec(input int k, input vec_t v, input string nm);
        int cyc;
        @(negedge clk);
        d_valid[k] = 1'b1; d_signed[k] = v.sgn; d_num[k] = v.num; d_den[k] = v.den;
        d_tag[k] = v.tag;  d_ready[k] = 1'b1;
        #1;
        chk({nm, "_in_ready"}, 32'(o_rdy[k]), 32'd1);
        @(posedge clk);
        #1;
        d_valid[k] = 1'b0; d_num[k] = $urandom; d_den[k] = $urandom; d_signed[k] = ~v.sgn;
        cyc = 1;
        while (!o_valid[k] && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({nm, "_latency"}, 32'(cyc), 32'(cfg_l[k]));
        chk({nm, "_coc"}, o_coc[k], v.coc);
        chk({nm, "_res"}, o_res[k], v.res);
        chk({nm, "_tag"}, 32'(o_tag[k]), 32'(v.tag));
        chk({nm, "_div0"}, 32'(o_div0[k]), 32'(v.dz));
        chk({nm, "_ovf"}, 32'(o_ovf[k]), 32'(v.ov));
        @(posedge clk);
    endtask

    task automatic run_stream(input int k, input int n, input int st_start, input int st_len, input string nm);
        logic [31:0] eq_coc[$], eq_res[$];
        logic [3:0]  eq_tag[$];
        logic        eq_dz[$], eq_ov[$];
        logic [31:0] q, r, s_coc, s_res;
        logic [3:0]  s_tag;
        logic        dz, ov, stall, pending, held;
        int sent, got, cyc;
        sent = 0; got = 0; cyc = 0; pending = 0; held = 0;
        s_coc = '0; s_res = '0; s_tag = '0;
        while (got < n && cyc < n + st_len + 200) begin
            @(negedge clk);
            stall = (cyc >= st_start) && (cyc < st_start + st_len);
            d_ready[k] = !stall;
            if (!pending && sent < n) begin
                d_signed[k] = 1'($urandom_range(0, 1));
                d_num[k]    = $urandom;
                case ($urandom_range(0, 9))
                    0:       d_den[k] = 32'd0;
                    1: begin d_den[k] = 32'hFFFF_FFFF; d_num[k] = 32'd1 << (cfg_w[k] - 1); end
                    2, 3, 4: d_den[k] = $urandom_range(1, 50);
                    default: d_den[k] = $urandom;
                endcase
                d_tag[k]   = 4'(sent);
                d_valid[k] = 1'b1;
                pending    = 1'b1;
            end else if (!pending) begin
                d_valid[k] = 1'b0;
            end
            #1;
            if (o_valid[k]) begin
                if (stall) begin
                    chk({nm, "_stall_in_ready"}, 32'(o_rdy[k]), 32'd0);
                    if (held) begin
                        chk({nm, "_stall_coc"}, o_coc[k], s_coc);
                        chk({nm, "_stall_res"}, o_res[k], s_res);
                        chk({nm, "_stall_tag"}, 32'(o_tag[k]), 32'(s_tag));
                    end
                    s_coc = o_coc[k]; s_res = o_res[k]; s_tag = o_tag[k]; held = 1'b1;
                end else if (eq_coc.size() == 0) begin
                    chk({nm, "_extra_result"}, 32'd1, 32'd0);
                end else begin
                    chk({nm, "_coc"}, o_coc[k], eq_coc.pop_front());
                    chk({nm, "_res"}, o_res[k], eq_res.pop_front());
                    chk({nm, "_tag"}, 32'(o_tag[k]), 32'(eq_tag.pop_front()));
                    chk({nm, "_div0"}, 32'(o_div0[k]), 32'(eq_dz.pop_front()));
                    chk({nm, "_ovf"}, 32'(o_ovf[k]), 32'(eq_ov.pop_front()));
                    if (st_len == 0) chk({nm, "_timing"}, 32'(cyc), 32'(got + cfg_l[k]));
                    got++;
                    held = 1'b0;
                end
            end
            if (d_valid[k] && o_rdy[k]) begin
                ref_div(cfg_w[k], d_signed[k], d_num[k], d_den[k], q, r, dz, ov);
                eq_coc.push_back(q); eq_res.push_back(r); eq_tag.push_back(d_tag[k]);
                eq_dz.push_back(dz); eq_ov.push_back(ov);
                sent++;
                pending = 1'b0;
            end
            cyc++;
        end
        d_valid[k] = 1'b0;
        d_ready[k] = 1'b1;
        chk({nm, "_count"}, 32'(got), 32'(n));
    endtask

    initial begin
        int emitted;
        vecs[0]  = '{1'b0, 32'd100,        32'd7,          4'd3,  32'd14,         32'd2,          1'b0, 1'b0};
        vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          4'd1,  32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 1'b0};
        vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  4'd2,  32'hFFFF_FFFD,  32'd1,          1'b0, 1'b0};
        vecs[3]  = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  4'd4,  32'd3,          32'hFFFF_FFFF,  1'b0, 1'b0};
        vecs[4]  = '{1'b0, 32'h1234,       32'd0,          4'd5,  32'hFFFF_FFFF,  32'h1234,       1'b1, 1'b0};
        vecs[5]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  4'd6,  32'h8000_0000,  32'd0,          1'b0, 1'b1};
        vecs[6]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          4'd7,  32'hFFFF_FFFF,  32'd0,          1'b0, 1'b0};
        vecs[7]  = '{1'b0, 32'd5,          32'd10,         4'd8,  32'd0,          32'd5,          1'b0, 1'b0};
        vecs[8]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  4'd9,  32'd0,          32'h8000_0000,  1'b0, 1'b0};
        vecs[9]  = '{1'b1, 32'h1234,       32'd0,          4'd10, 32'hFFFF_FFFF,  32'h1234,       1'b1, 1'b0};
        vecs[10] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  4'd11, 32'd1,          32'd0,          1'b0, 1'b0};
        vecs[11] = '{1'b1, 32'h8000_0000,  32'd2,          4'd12, 32'hC000_0000,  32'd0,          1'b0, 1'b0};
        vecs[12] = '{1'b1, 32'hFFFF_FFFF,  32'd0,          4'd13, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 1'b0};

        for (int k = 0; k < 3; k++) begin
            d_valid[k] = 1'b0; d_signed[k] = 1'b0; d_ready[k] = 1'b1;
            d_num[k] = '0; d_den[k] = '0; d_tag[k] = '0;
        end

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_out_valid", 32'(o_valid[k]), 32'd0);
            chk("rst_in_ready", 32'(o_rdy[k]), 32'd0);
            chk("rst_coc", o_coc[k], 32'd0);
            chk("rst_res", o_res[k], 32'd0);
            chk("rst_tag", 32'(o_tag[k]), 32'd0);
            chk("rst_flags", 32'({o_div0[k], o_ovf[k]}), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) chk("rel_in_ready", 32'(o_rdy[k]), 32'd1);

        for (int i = 0; i < 13; i++) run_vec(0, vecs[i], $sformatf("vec%0d", i));

        run_stream(0, 64, 0, 0, "b2b_w32");
        run_stream(0, 30, 39, 10, "stall_w32");
        run_stream(1, 64, 0, 0, "b2b_w8");
        run_stream(1, 30, 11, 10, "stall_w8");
        run_stream(2, 64, 0, 0, "b2b_w16");
        run_stream(2, 30, 11, 10, "stall_w16");

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            d_valid[0] = 1'b1; d_signed[0] = 1'b0; d_num[0] = 32'(10 + i); d_den[0] = 32'd3;
            d_tag[0] = 4'(i); d_ready[0] = 1'b1;
        end
        @(negedge clk);
        d_valid[0] = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("inflight_rst_out_valid", 32'(o_valid[0]), 32'd0);
        chk("inflight_rst_in_ready", 32'(o_rdy[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("inflight_rel_in_ready", 32'(o_rdy[0]), 32'd1);
        emitted = 0;
        repeat (cfg_l[0] + 10) begin
            @(posedge clk);
            #1;
            if (o_valid[0]) emitted++;
        end
        chk("inflight_discarded", 32'(emitted), 32'd0);
        run_vec(0, '{1'b0, 32'd20, 32'd3, 4'd14, 32'd6, 32'd2, 1'b0, 1'b0}, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
